// File: rtl/mem_access_unit.sv
// mem_access_unit
// Translates lw/lh/lhu/lb/lbu/sw/sh/sb requests from the EX/MEM stage into
// transactions on a word-wide data memory. The memory writes whole words
// only and returns read data one cycle after mem_read.
//   - Word stores go straight out in the accept cycle (no stall).
//   - Loads read the word, then extract and extend the addressed lane.
//   - Byte/half stores read the word, merge the new lane, and write it back.
//   - Misaligned requests (and size 3) touch no memory and pulse access_err.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   req_*               request handshake and fields from the pipeline
//   mem_*               data memory interface (word address, word data)
//   load_valid/data     one-cycle load completion and extended result
//   access_err          one-cycle pulse for a rejected (misaligned) request
module mem_access_unit #(
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        access_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_RESP = 2'd1,
    RMW_MERGE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] lat_addr;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [15:0] lat_wdata;

  logic        req_misaligned;
  logic [4:0]  shift;
  logic [31:0] shifted;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;
  logic [31:0] merged;
  logic [31:0] extended;

  // Bit offset of the addressed lane inside the word. Big-endian puts byte 0
  // in the most significant position, so the offset counts down from the top.
  function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] low);
    logic [4:0] sh;
    case (size)
      2'd0:    sh = LITTLE_ENDIAN ? {low, 3'b000} : (5'd24 - {low, 3'b000});
      2'd1:    sh = LITTLE_ENDIAN ? {low[1], 4'b0000} : (5'd16 - {low[1], 4'b0000});
      default: sh = 5'd0;
    endcase
    return sh;
  endfunction

  // Size 3 is never legal; halves need even, words need 4-byte alignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] low);
    logic mis;
    case (size)
      2'd0:    mis = 1'b0;
      2'd1:    mis = low[0];
      2'd2:    mis = (low != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

  assign req_misaligned = is_misaligned(req_size, req_addr[1:0]);

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    shift     = lane_shift(lat_size, lat_addr[1:0]);
    shifted   = mem_rdata >> shift;
    lane_mask = 32'h0000_0000;
    lane_data = 32'h0000_0000;
    extended  = shifted;
    case (lat_size)
      2'd0: begin
        lane_mask = 32'h0000_00FF << shift;
        lane_data = {24'h00_0000, lat_wdata[7:0]} << shift;
        extended  = lat_unsigned ? {24'h00_0000, shifted[7:0]}
                                 : {{24{shifted[7]}}, shifted[7:0]};
      end
      2'd1: begin
        lane_mask = 32'h0000_FFFF << shift;
        lane_data = {16'h0000, lat_wdata} << shift;
        extended  = lat_unsigned ? {16'h0000, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        lane_mask = 32'h0000_0000;
        lane_data = 32'h0000_0000;
        extended  = shifted;
      end
    endcase
    merged = (mem_rdata & ~lane_mask) | lane_data;
  end

  // Memory strobes and handshake; word stores issue in the accept cycle, so
  // these are driven from state and request inputs, and forced idle in reset.
  always_comb begin
    req_ready = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = {req_addr[31:2], 2'b00};
    mem_wdata = req_wdata;
    if (reset) begin
      req_ready = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready = 1'b1;
          if (req_valid && !req_misaligned) begin
            if (req_write && (req_size == 2'd2)) begin
              mem_write = 1'b1;
            end else begin
              mem_read = 1'b1;
            end
          end else begin
            mem_read = 1'b0;
          end
        end
        LOAD_RESP: begin
          mem_addr = {lat_addr[31:2], 2'b00};
        end
        RMW_MERGE: begin
          mem_write = 1'b1;
          mem_addr  = {lat_addr[31:2], 2'b00};
          mem_wdata = merged;
        end
        default: begin
          req_ready = 1'b0;
        end
      endcase
    end
  end

  // Control FSM with registered completion/error pulses and latched request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      lat_addr     <= 32'h0000_0000;
      lat_size     <= 2'd0;
      lat_unsigned <= 1'b0;
      lat_wdata    <= 16'h0000;
      load_valid   <= 1'b0;
      load_data    <= 32'h0000_0000;
      access_err   <= 1'b0;
    end else begin
      load_valid <= 1'b0;
      access_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_addr     <= req_addr;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_wdata    <= req_wdata[15:0];
            if (req_misaligned) begin
              access_err <= 1'b1;
            end else if (req_write && (req_size == 2'd2)) begin
              state <= IDLE;
            end else if (req_write) begin
              state <= RMW_MERGE;
            end else begin
              state <= LOAD_RESP;
            end
          end
        end
        LOAD_RESP: begin
          load_data  <= extended;
          load_valid <= 1'b1;
          state      <= IDLE;
        end
        RMW_MERGE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (little-endian build).
// A word-array memory with one-cycle read latency sits on the mem_* port.
// Expected results come from a byte-addressed reference image updated with
// the load/store semantics directly (lanes assembled from bytes).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        load_valid;
  logic [31:0] load_data;
  logic        access_err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:63];
  logic [31:0] pre [0:63];
  logic        preload;
  logic [7:0]  refb [0:255];
  logic [31:0] last_load;

  mem_access_unit #(.LITTLE_ENDIAN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .load_valid(load_valid), .load_data(load_data), .access_err(access_err)
  );

  always #5 clk = ~clk;

  // Data memory: word writes, registered read.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= pre[i];
    end else begin
      if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
      if (mem_read)  mem_rdata <= mem[mem_addr[7:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {refb[4*w+3], refb[4*w+2], refb[4*w+1], refb[4*w]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit un, input logic [31:0] a);
    int b;
    logic [31:0] v;
    b = int'(a[7:0]);
    case (sz)
      2'd0: begin
        v = {24'h0, refb[b]};
        if (!un && v[7]) v = v | 32'hFFFF_FF00;
      end
      2'd1: begin
        v = {16'h0, refb[b+1], refb[b]};
        if (!un && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = {refb[b+3], refb[b+2], refb[b+1], refb[b]};
    endcase
    return v;
  endfunction

  function automatic bit ref_mis(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
  endfunction

  // Issue one request and check every cycle of its transaction.
  task automatic do_req(input bit wr, input logic [1:0] sz, input bit un,
                        input logic [31:0] a, input logic [31:0] wd);
    bit mis;
    int nbytes;
    logic [31:0] exp;
    mis = ref_mis(sz, a);
    @(negedge clk);
    chk("idle_access_err", {31'h0, access_err}, 32'h0);
    chk("idle_load_valid", {31'h0, load_valid}, 32'h0);
    chk("load_data_hold", load_data, last_load);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = un;
    req_addr = a; req_wdata = wd;
    #1;
    chk("req_ready", {31'h0, req_ready}, 32'h1);
    if (mis) begin
      chk("mis_no_read", {31'h0, mem_read}, 32'h0);
      chk("mis_no_write", {31'h0, mem_write}, 32'h0);
    end else if (wr && sz == 2'd2) begin
      chk("sw_write", {31'h0, mem_write}, 32'h1);
      chk("sw_no_read", {31'h0, mem_read}, 32'h0);
      chk("sw_addr", mem_addr, {a[31:2], 2'b00});
      chk("sw_wdata", mem_wdata, wd);
    end else begin
      chk("rd_strobe", {31'h0, mem_read}, 32'h1);
      chk("rd_no_write", {31'h0, mem_write}, 32'h0);
      chk("rd_addr", mem_addr, {a[31:2], 2'b00});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (mis) begin
      @(negedge clk);
      chk("err_pulse", {31'h0, access_err}, 32'h1);
      chk("err_no_load_valid", {31'h0, load_valid}, 32'h0);
      chk("err_no_strobe", {30'h0, mem_read, mem_write}, 32'h0);
    end else if (wr) begin
      nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      for (int k = 0; k < nbytes; k++) refb[int'(a[7:0]) + k] = wd[8*k +: 8];
      if (sz != 2'd2) begin
        @(negedge clk);
        chk("rmw_ready_low", {31'h0, req_ready}, 32'h0);
        chk("rmw_write", {30'h0, mem_read, mem_write}, 32'h1);
        chk("rmw_addr", mem_addr, {a[31:2], 2'b00});
        chk("rmw_wdata", mem_wdata, ref_word(int'(a[7:2])));
      end
    end else begin
      exp = ref_load(sz, un, a);
      @(negedge clk);
      chk("ld_ready_low", {31'h0, req_ready}, 32'h0);
      chk("ld_no_strobe", {30'h0, mem_read, mem_write}, 32'h0);
      @(negedge clk);
      chk("ld_valid", {31'h0, load_valid}, 32'h1);
      chk("ld_no_err", {31'h0, access_err}, 32'h0);
      chk("ld_data", load_data, exp);
      last_load = exp;
    end
  endtask

  initial begin
    bit wr;
    logic [1:0] sz;
    logic [31:0] a;
    reset = 1'b1; preload = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    last_load = 32'h0;
    for (int i = 0; i < 64; i++) begin
      pre[i] = (i == 4) ? 32'h8899_AABB : $urandom;
      for (int k = 0; k < 4; k++) refb[4*i+k] = pre[i][8*k +: 8];
    end

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    chk("rst_load_valid", {31'h0, load_valid}, 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_access_err", {31'h0, access_err}, 32'h0);
    @(posedge clk); #1;
    preload = 1'b0; reset = 1'b0;

    // Directed loads on 0x8899AABB at 0x10.
    do_req(1'b0, 2'd0, 1'b0, 32'h12, 32'h0);
    chk("lb_0x12", last_load, 32'hFFFF_FF99);
    do_req(1'b0, 2'd0, 1'b1, 32'h12, 32'h0);
    chk("lbu_0x12", last_load, 32'h0000_0099);
    do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    chk("lh_0x12", last_load, 32'hFFFF_8899);
    do_req(1'b0, 2'd1, 1'b1, 32'h10, 32'h0);
    chk("lhu_0x10", last_load, 32'h0000_AABB);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    chk("lw_0x10", last_load, 32'h8899_AABB);

    // Sub-word store read-modify-write.
    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h1234_5677);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    chk("sb_result", last_load, 32'h8899_77BB);

    // Back-to-back word stores, then read back.
    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEAD_BEEF);
    do_req(1'b1, 2'd2, 1'b0, 32'h24, 32'h0102_0304);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    chk("sw_readback", last_load, 32'hDEAD_BEEF);

    // Misaligned / illegal requests.
    do_req(1'b0, 2'd1, 1'b0, 32'h13, 32'h0);
    do_req(1'b1, 2'd2, 1'b0, 32'h22, 32'hCAFE_F00D);
    do_req(1'b0, 2'd3, 1'b0, 32'h00, 32'h0);

    // Reset while in RMW_MERGE: the write must be abandoned.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
    req_addr = 32'h14; req_wdata = 32'h0000_5A5A;
    #1;
    chk("sh_read", {30'h0, mem_read, mem_write}, 32'h2);
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_no_write", {30'h0, mem_read, mem_write}, 32'h0);
    chk("abort_ready_low", {31'h0, req_ready}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    last_load = 32'h0;
    @(negedge clk);
    chk("post_abort_ready", {31'h0, req_ready}, 32'h1);
    chk("post_abort_load_valid", {31'h0, load_valid}, 32'h0);
    chk("post_abort_word", mem[5], ref_word(5));

    // Randomized traffic against the byte-level reference.
    for (int n = 0; n < 60; n++) begin
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      do_req(wr, sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    // Final memory image must match the reference.
    @(negedge clk);
    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_word(i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
